planta_rega: RTL
================

PLANTA_REGA -- requirements
Module: planta_rega

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, giving clock cycles per simulation tick (range 1..2^20).
REQ-002 SHALL have parameter LOW_TH, default 40, giving the tank volume at or above which lowLevel asserts.
REQ-003 SHALL have parameter MED_TH, default 120, giving the volume threshold for mediumLevel.
REQ-004 SHALL have parameter HIGH_TH, default 200, giving the volume threshold for highLevel.
REQ-005 SHALL have parameter FILL_RATE, default 4, giving volume units added per tick while the inlet valve is open.
REQ-006 SHALL have parameters DRIP_RATE (default 1) and SPRAY_RATE (default 3), giving volume units drawn per tick by each watering mode.
REQ-007 SHALL have parameters SOIL_ON (default 160) and SOIL_OFF (default 96), giving the soil-moisture hysteresis thresholds.
REQ-008 SHALL have port clock, input, 1 bit: the single clock.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port valvulaEntrada, input, 1 bit: inlet valve open.
REQ-011 SHALL have port gotejamento, input, 1 bit: drip irrigation active.
REQ-012 SHALL have port aspersao, input, 1 bit: sprinkler irrigation active.
REQ-013 SHALL have ports highLevel, mediumLevel and lowLevel, each output, 1 bit: tank sensors, 1 = water at or above the sensor.
REQ-014 SHALL have port umidadeSolo, output, 1 bit: soil wet.
REQ-015 SHALL have port nivelVolume, output, 8 bits: current tank volume (debug).

Function
REQ-016 SHALL run a prescaler counter that pulses an internal tick for one cycle every TICK_DIV cycles; TICK_DIV=1 SHALL tick every cycle.
REQ-017 SHALL update state only on tick; between ticks all state holds.
REQ-018 On tick, volume SHALL change by +FILL_RATE·valvulaEntrada −DRIP_RATE·gotejamento −SPRAY_RATE·aspersao, computed as one signed sum and saturated to 0..255.
REQ-019 Simultaneous fill and draw SHALL use the net sum only, with no intermediate saturation.
REQ-020 On tick, soil moisture (8 bits) SHALL add 2 if gotejamento, add 4 if aspersao and subtract 1 for evaporation, saturating to 0..255; watering credit SHALL apply only when the pre-tick volume is >0.
REQ-021 The sensor outputs SHALL be lowLevel=(vol≥LOW_TH), mediumLevel=(vol≥MED_TH) and highLevel=(vol≥HIGH_TH), decoded from the registered volume.
REQ-022 Soil SHALL use a 2-state FSM, SECO→UMIDO when moisture≥SOIL_ON and UMIDO→SECO when moisture<SOIL_OFF; umidadeSolo=1 in UMIDO.
REQ-023 Outputs SHALL reflect a tick's update in the cycle after the tick pulse, giving 1-cycle latency.

Reset
REQ-024 On reset, volume, moisture and prescaler SHALL be 0, the FSM SHALL be SECO, and all outputs SHALL be 0; the tick SHALL be suppressed in the reset cycle.
REQ-025 Reset asserted mid-tick SHALL win over the update, and the prescaler SHALL restart a full TICK_DIV period after release.

Configuration
REQ-026 With PLANTA_FALHA_SENSOR_EN defined, the module SHALL add an input falhaSensor (1 bit) that, while high, forces mediumLevel=0 regardless of volume, to inject the high-without-medium fault; internal state SHALL be unaffected.
REQ-027 Without PLANTA_FALHA_SENSOR_EN, the falhaSensor port SHALL be absent and the sensors SHALL follow REQ-021 exactly.

Structure
REQ-028 Shared package planta_pkg SHALL hold the threshold and rate default constants and the soil FSM state enum (SECO, UMIDO).
REQ-029 The prescaler SHALL be a sub-module named gerador_tick with parameter DIV and output tick.

Verification
REQ-030 Bench SHALL run with TICK_DIV=1: reset, then valvulaEntrada=1 for 50 ticks -> vol=200 and high=medium=low=1.
REQ-031 Bench SHALL cover saturation: from vol=252, fill one tick -> vol=255, not wrapped to 0.
REQ-032 Bench SHALL cover the net sum: at vol=100 apply valve+drip+spray for one tick -> vol=100.
REQ-033 Bench SHALL cover soil hysteresis: from vol=200, spray only for 54 ticks -> moisture=162 and umidadeSolo=1; then idle 66 ticks -> moisture=96 and still 1; one more tick -> 0.
REQ-034 Bench SHALL cover reset mid-run: with vol=130, reset for 1 cycle -> all outputs 0 and vol=0 on the next cycle.
REQ-035 With PLANTA_FALHA_SENSOR_EN, bench SHALL cover fault injection: vol=210 and falhaSensor=1 -> highLevel=1, mediumLevel=0, lowLevel=1.

Source files
------------

// File: rtl/planta_pkg.sv
// Shared constants, soil FSM state type and saturation helper for the irrigation plant model.
package planta_pkg;

    localparam int TICK_DIV_DEF   = 1000;
    localparam int LOW_TH_DEF     = 40;
    localparam int MED_TH_DEF     = 120;
    localparam int HIGH_TH_DEF    = 200;
    localparam int FILL_RATE_DEF  = 4;
    localparam int DRIP_RATE_DEF  = 1;
    localparam int SPRAY_RATE_DEF = 3;
    localparam int SOIL_ON_DEF    = 160;
    localparam int SOIL_OFF_DEF   = 96;

    // Soil moisture credit per tick for each watering mode, and evaporation loss.
    localparam int SOIL_DRIP_GAIN  = 2;
    localparam int SOIL_SPRAY_GAIN = 4;
    localparam int SOIL_EVAP_LOSS  = 1;

    localparam int NUM_SENSORS = 3;
    localparam int SENSOR_LOW  = 0;
    localparam int SENSOR_MED  = 1;
    localparam int SENSOR_HIGH = 2;

    typedef enum logic {
        SECO  = 1'b0,
        UMIDO = 1'b1
    } solo_estado_t;

    function automatic logic [7:0] sat_u8(input int value);
        if (value < 0) begin
            return 8'd0;
        end else if (value > 255) begin
            return 8'd255;
        end else begin
            return value[7:0];
        end
    endfunction

endpackage

// File: rtl/planta_rega_gerador_tick.sv
// Prescaler: one-cycle tick every DIV clocks; restarts a full period after reset release.
module gerador_tick #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic srst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Gated by reset so no update can slip through in the reset cycle.
    assign tick = w_wrap & ~srst;

endmodule

// File: rtl/planta_rega.sv
// Irrigation plant model: tank volume, soil moisture with hysteresis FSM, level sensors.
// Optional PLANTA_FALHA_SENSOR_EN adds falhaSensor, which masks mediumLevel.
module planta_rega
    import planta_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int LOW_TH     = LOW_TH_DEF,
    parameter int MED_TH     = MED_TH_DEF,
    parameter int HIGH_TH    = HIGH_TH_DEF,
    parameter int FILL_RATE  = FILL_RATE_DEF,
    parameter int DRIP_RATE  = DRIP_RATE_DEF,
    parameter int SPRAY_RATE = SPRAY_RATE_DEF,
    parameter int SOIL_ON    = SOIL_ON_DEF,
    parameter int SOIL_OFF   = SOIL_OFF_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valvulaEntrada,
    input  logic       gotejamento,
    input  logic       aspersao,
`ifdef PLANTA_FALHA_SENSOR_EN
    input  logic       falhaSensor,
`endif
    output logic       highLevel,
    output logic       mediumLevel,
    output logic       lowLevel,
    output logic       umidadeSolo,
    output logic [7:0] nivelVolume
);

    localparam logic [7:0] SOIL_ON8  = SOIL_ON[7:0];
    localparam logic [7:0] SOIL_OFF8 = SOIL_OFF[7:0];
    localparam logic [8*NUM_SENSORS-1:0] SENSOR_TH = {HIGH_TH[7:0], MED_TH[7:0], LOW_TH[7:0]};

    logic                    w_tick;
    logic [7:0]              r_vol;
    logic [7:0]              r_soil;
    logic [7:0]              w_vol_next;
    logic [7:0]              w_soil_next;
    int                      w_vol_sum;
    int                      w_soil_sum;
    solo_estado_t            r_state;
    solo_estado_t            w_state_next;
    logic [NUM_SENSORS-1:0]  w_sensor;

    gerador_tick #(
        .DIV (TICK_DIV)
    ) u_gerador_tick (
        .clk  (clock),
        .srst (reset),
        .tick (w_tick)
    );

    // Net sum is formed at full width first, so fill and draw cancel before saturation.
    always_comb begin
        w_vol_sum = int'(r_vol);
        if (valvulaEntrada) begin
            w_vol_sum = w_vol_sum + FILL_RATE;
        end
        if (gotejamento) begin
            w_vol_sum = w_vol_sum - DRIP_RATE;
        end
        if (aspersao) begin
            w_vol_sum = w_vol_sum - SPRAY_RATE;
        end
        w_vol_next = sat_u8(w_vol_sum);
    end

    // Watering only wets the soil when the tank actually had water before this tick.
    always_comb begin
        w_soil_sum = int'(r_soil) - SOIL_EVAP_LOSS;
        if (r_vol != 8'd0) begin
            if (gotejamento) begin
                w_soil_sum = w_soil_sum + SOIL_DRIP_GAIN;
            end
            if (aspersao) begin
                w_soil_sum = w_soil_sum + SOIL_SPRAY_GAIN;
            end
        end
        w_soil_next = sat_u8(w_soil_sum);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vol  <= 8'd0;
            r_soil <= 8'd0;
        end else if (w_tick) begin
            r_vol  <= w_vol_next;
            r_soil <= w_soil_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= SECO;
        end else if (w_tick) begin
            r_state <= w_state_next;
        end
    end

    // Transitions judge the moisture this tick produces, so state and moisture stay in step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SECO:    if (w_soil_next >= SOIL_ON8)  w_state_next = UMIDO;
            UMIDO:   if (w_soil_next <  SOIL_OFF8) w_state_next = SECO;
            default: w_state_next = SECO;
        endcase
    end

    always_comb begin
        umidadeSolo = (r_state == UMIDO);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
            assign w_sensor[gi] = (r_vol >= SENSOR_TH[gi*8 +: 8]);
        end
    endgenerate

    assign lowLevel  = w_sensor[SENSOR_LOW];
    assign highLevel = w_sensor[SENSOR_HIGH];
`ifdef PLANTA_FALHA_SENSOR_EN
    assign mediumLevel = w_sensor[SENSOR_MED] & ~falhaSensor;
`else
    assign mediumLevel = w_sensor[SENSOR_MED];
`endif
    assign nivelVolume = r_vol;

endmodule
